// File: rtl/synth_i2c_pkg.sv
// Shared types and constants for the I2C synth-control target.
package synth_i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWr,
        StWrAck,
        StRd,
        StRdAck
    } i2c_state_e;

    localparam logic [2:0] REG_MASTER_VOL = 3'd0;
    localparam logic [2:0] REG_REVERB     = 3'd1;
    localparam logic [2:0] REG_VIBRATO    = 3'd2;
    localparam logic [2:0] REG_KEYCODE    = 3'd3;
    localparam logic [2:0] REG_GP0        = 3'd4;
    localparam logic [2:0] REG_GP1        = 3'd5;
    localparam logic [2:0] REG_GP2        = 3'd6;
    localparam logic [2:0] REG_GP3        = 3'd7;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h2A;
    localparam logic [3:0] BITS_PER_BYTE       = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_line_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic scl_meta_d, scl_sync_d, scl_prev_d;
    logic sda_meta_d, sda_sync_d, sda_prev_d;

    always_comb begin
        scl_meta_d = scl_i;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = sda_i;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;
    end

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_o      = sda_sync_q;
    assign scl_rise_o = scl_sync_q & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q & scl_prev_q;
    assign start_o    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_o     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_synth_target.sv
// I2C target exposing an 8-entry register file with an auto-incrementing pointer.
module i2c_synth_target
    import synth_i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR    = DEFAULT_TARGET_ADDR,
    parameter logic [7:0] MASTER_VOL_RST = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] keycode,
    output logic [7:0] master_vol,
    output logic [7:0] reverb,
    output logic [7:0] vibrato,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk_i      (clk),
        .reset_i    (reset),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            ack_q, ack_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [2:0]      wr_addr_q, wr_addr_d;
    logic [7:0][7:0] regs_q, regs_d;

    logic [2:0] ptr_inc;
    logic [7:0] rd_cur, rd_next;

    assign ptr_inc = ptr_q + 3'd1;
    assign rd_cur  = (ptr_q == REG_KEYCODE) ? keycode : regs_q[ptr_q];
    assign rd_next = (ptr_inc == REG_KEYCODE) ? keycode : regs_q[ptr_inc];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        // Bus conditions win over any SCL edge seen in the same cycle.
        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = StAddr;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sda_oe_d = 1'b0;
                end
                StAddr, StReg, StWr: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        cnt_d = 4'd0;
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_d  = StAddrAck;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d = StIdle;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == StReg) begin
                            state_d  = StRegAck;
                            sda_oe_d = 1'b1;
                            ptr_d    = shift_q[2:0];
                        end else begin
                            state_d  = StWrAck;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = StRd;
                            shift_d  = rd_cur;
                            sda_oe_d = ~rd_cur[7];
                        end else begin
                            state_d  = StReg;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StRegAck: begin
                    if (scl_fall) begin
                        state_d  = StWr;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state_d     = StWr;
                        cnt_d       = 4'd0;
                        sda_oe_d    = 1'b0;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        ptr_d       = ptr_inc;
                        if (ptr_q != REG_KEYCODE) begin
                            regs_d[ptr_q] = shift_q;
                        end
                    end
                end
                StRd: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        state_d  = StRdAck;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (ack_q) begin
                            state_d  = StRd;
                            ptr_d    = ptr_inc;
                            shift_d  = rd_next;
                            sda_oe_d = ~rd_next[7];
                        end else begin
                            state_d  = StIdle;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                 <= StIdle;
            cnt_q                   <= 4'd0;
            shift_q                 <= 8'h00;
            ptr_q                   <= 3'd0;
            rw_q                    <= 1'b0;
            ack_q                   <= 1'b0;
            sda_oe_q                <= 1'b0;
            busy_q                  <= 1'b0;
            wr_strobe_q             <= 1'b0;
            wr_addr_q               <= 3'd0;
            regs_q                  <= '0;
            regs_q[REG_MASTER_VOL]  <= MASTER_VOL_RST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign master_vol = regs_q[REG_MASTER_VOL];
    assign reverb     = regs_q[REG_REVERB];
    assign vibrato    = regs_q[REG_VIBRATO];

endmodule

// File: tb/tb_i2c_synth_target.sv
// Bench for i2c_synth_target: bit-banged I2C master with write/read scoreboards.
module tb_i2c_synth_target;

    localparam time Q = 100ns;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] keycode = 8'h00;
    logic [7:0] master_vol, reverb, vibrato;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic       busy;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    logic [10:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_synth_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .keycode    (keycode),
        .master_vol (master_vol),
        .reverb     (reverb),
        .vibrato    (vibrato),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    always #5ns clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write scoreboard: each strobe pops {addr, data}.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            if (exp_wr_q.size() == 0) begin
                check_val("wr_unexpected", 32'(wr_addr), 32'hFFFF);
            end else begin
                logic [10:0] e;
                e = exp_wr_q.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(e[10:8]));
                if (e[10:8] == 3'd0) check_val("wr_master_vol", 32'(master_vol), 32'(e[7:0]));
                if (e[10:8] == 3'd1) check_val("wr_reverb", 32'(reverb), 32'(e[7:0]));
                if (e[10:8] == 3'd2) check_val("wr_vibrato", 32'(vibrato), 32'(e[7:0]));
            end
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b1; #Q;
        #Q;
    endtask

    task automatic send_bit(input logic b, output logic r);
        sda_m = b;  #Q;
        scl = 1'b1; #Q;
        r = sda_bus; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(d[i], r);
        send_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            d[i] = r;
        end
        send_bit(~ack, r);
    endtask

    task automatic wr_ok(input string tag, input logic [7:0] d);
        logic ack;
        write_byte(d, ack);
        check_val(tag, 32'(ack), 32'd1);
    endtask

    task automatic wr_data(input string tag, input logic [2:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
        wr_ok(tag, d);
    endtask

    task automatic rd_chk(input string tag, input logic ack, input logic [7:0] exp);
        logic [7:0] d;
        exp_rd_q.push_back(exp);
        read_byte(ack, d);
        check_val(tag, 32'(d), 32'(exp_rd_q.pop_front()));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic r;
        int sc;
        bit seen;

        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_master_vol", 32'(master_vol), 32'h80);
        check_val("rst_reverb", 32'(reverb), 32'h00);
        check_val("rst_vibrato", 32'(vibrato), 32'h00);

        // Single write to master_vol.
        i2c_start();
        wr_ok("w1_addr_ack", 8'h54);
        check_val("w1_busy", 32'(busy), 32'd1);
        wr_ok("w1_reg_ack", 8'h00);
        wr_data("w1_data_ack", 3'd0, 8'h40);
        i2c_stop();
        check_val("w1_master_vol", 32'(master_vol), 32'h40);
        check_val("w1_strobes", 32'(strobe_cnt), 32'd1);
        check_val("w1_busy_after", 32'(busy), 32'd0);

        // Burst write with pointer wrap 7 -> 0.
        i2c_start();
        wr_ok("w2_addr_ack", 8'h54);
        wr_ok("w2_reg_ack", 8'h06);
        wr_data("w2_d6", 3'd6, 8'h11);
        wr_data("w2_d7", 3'd7, 8'h22);
        wr_data("w2_d0", 3'd0, 8'h33);
        i2c_stop();
        check_val("w2_master_vol", 32'(master_vol), 32'h33);
        check_val("w2_strobes", 32'(strobe_cnt), 32'd4);

        // Reverb / vibrato, then read 6,7 back via repeated start.
        i2c_start();
        wr_ok("w3_addr_ack", 8'h54);
        wr_ok("w3_reg_ack", 8'h01);
        wr_data("w3_d1", 3'd1, 8'hA5);
        wr_data("w3_d2", 3'd2, 8'h3C);
        i2c_stop();
        check_val("w3_reverb", 32'(reverb), 32'hA5);
        check_val("w3_vibrato", 32'(vibrato), 32'h3C);

        i2c_start();
        wr_ok("r1_addr_ack", 8'h54);
        wr_ok("r1_reg_ack", 8'h06);
        i2c_start();
        wr_ok("r1_raddr_ack", 8'h55);
        rd_chk("r1_gp2", 1'b1, 8'h11);
        rd_chk("r1_gp3", 1'b0, 8'h22);
        i2c_stop();

        // Keycode register: writes strobe but do not stick; reads are live.
        keycode = 8'h5C;
        i2c_start();
        wr_ok("k_addr_ack", 8'h54);
        wr_ok("k_reg_ack", 8'h03);
        wr_data("k_data_ack", 3'd3, 8'h99);
        i2c_stop();
        i2c_start();
        wr_ok("k2_addr_ack", 8'h54);
        wr_ok("k2_reg_ack", 8'h03);
        i2c_start();
        wr_ok("k2_raddr_ack", 8'h55);
        rd_chk("k2_keycode", 1'b0, 8'h5C);
        #Q;
        check_val("k2_nack_release", 32'(sda_oe), 32'd0);
        check_val("k2_nack_busy", 32'(busy), 32'd0);
        i2c_stop();

        // Wrong address: no ACK, nothing changes.
        sc = strobe_cnt;
        i2c_start();
        write_byte(8'h56, ack);
        check_val("na_ack", 32'(ack), 32'd0);
        check_val("na_busy", 32'(busy), 32'd0);
        write_byte(8'h00, ack);
        check_val("na_ack2", 32'(ack), 32'd0);
        write_byte(8'h77, ack);
        i2c_stop();
        check_val("na_master_vol", 32'(master_vol), 32'h33);
        check_val("na_strobes", 32'(strobe_cnt), 32'(sc));

        // STOP after four data bits: partial byte discarded.
        i2c_start();
        wr_ok("p_addr_ack", 8'h54);
        wr_ok("p_reg_ack", 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b1, r);
        i2c_stop();
        check_val("p_master_vol", 32'(master_vol), 32'h33);
        check_val("p_strobes", 32'(strobe_cnt), 32'(sc));
        check_val("p_busy", 32'(busy), 32'd0);
        write_byte(8'h54, ack);
        check_val("p_idle_noack", 32'(ack), 32'd0);
        i2c_stop();

        // Reset while the target drives a 0 bit (master_vol=0x33 has MSB 0).
        i2c_start();
        wr_ok("rr_addr_ack", 8'h54);
        wr_ok("rr_reg_ack", 8'h00);
        i2c_start();
        wr_ok("rr_raddr_ack", 8'h55);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (sda_oe) seen = 1'b1;
        end
        check_val("rr_driving", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1ns;
        check_val("rr_release", 32'(sda_oe), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rr_master_vol", 32'(master_vol), 32'h80);
        check_val("rr_reverb", 32'(reverb), 32'h00);
        check_val("rr_vibrato", 32'(vibrato), 32'h00);
        check_val("rr_busy", 32'(busy), 32'd0);
        i2c_stop();
        i2c_start();
        wr_ok("rr2_raddr_ack", 8'h55);
        rd_chk("rr2_ptr0", 1'b0, 8'h80);
        i2c_stop();
        i2c_start();
        wr_ok("rr3_addr_ack", 8'h54);
        wr_ok("rr3_reg_ack", 8'h06);
        i2c_start();
        wr_ok("rr3_raddr_ack", 8'h55);
        rd_chk("rr3_gp2", 1'b0, 8'h00);
        i2c_stop();

        check_val("wr_pending", 32'(exp_wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
